flash_hex_dump: RTL and testbench

// - Downstream formatter between the SPI flash byte reader and the UART TX.
// - Consumes one data byte per read-done pulse, plus the byte's flash address.
// - Emits a printable hex-dump line as single ASCII characters into the UART TX FIFO:
//   "AAAAAAAA: HH HH ... HH <CR><LF>".
// - Lets a board dump flash contents to a terminal without a CPU.
//

---
 rtl/flash_hex_dump.sv | 241 ++++++++++++++++++++++++
 tb/tb_flash_hex_dump.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_hex_dump.sv
// flash_hex_dump: formats flash bytes into ASCII hex-dump lines for a UART TX FIFO.
// Line format: "AAAAAAAA: HH HH ... HH <CR><LF>".
// Optional ASCII column enabled by defining HEXDUMP_ASCII_EN.
module flash_hex_dump #(
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter int unsigned ADDR_DIGITS    = 8
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iByteValid,
  input  logic [7:0]  iByte,
  input  logic [31:0] iAddr,
  input  logic        iFlush,
  output logic        oReady,
  output logic        oOverrun,
  output logic [7:0]  oTxData,
  output logic        oTxStart,
  input  logic        iTxFull
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_LINE + 1);
  localparam int unsigned IDX_W = 8;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_COLON = 4'd2;
  localparam logic [3:0] S_SP0   = 4'd3;
  localparam logic [3:0] S_HI    = 4'd4;
  localparam logic [3:0] S_LO    = 4'd5;
  localparam logic [3:0] S_SP1   = 4'd6;
`ifdef HEXDUMP_ASCII_EN
  localparam logic [3:0] S_PAD   = 4'd7;
  localparam logic [3:0] S_ASC   = 4'd8;
  localparam int unsigned BI_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
`endif
  localparam logic [3:0] S_CR    = 4'd9;
  localparam logic [3:0] S_LF    = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_q, flush_d;
  logic             ready_d, overrun_d, tx_start_d;
  logic [7:0]       tx_data_d;
  logic [7:0]       char_c;
  logic             emit_ok;
  logic [2:0]       dig_sel;

`ifdef HEXDUMP_ASCII_EN
  logic [7:0] line_buf [BYTES_PER_LINE];
  logic       buf_we;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef HEXDUMP_ASCII_EN
  function automatic logic [7:0] printable(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
  endfunction

  // Spaces needed to keep the '|' column aligned for a partial line of c bytes.
  function automatic logic [IDX_W-1:0] pad_len(input logic [CNT_W-1:0] c);
    return IDX_W'(3) * (IDX_W'(BYTES_PER_LINE) - IDX_W'(c));
  endfunction
`endif

  // Next-state, character selection and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    flush_d    = flush_q;
    tx_start_d = 1'b0;
    tx_data_d  = oTxData;
    char_c     = 8'h00;
    overrun_d  = oOverrun | (!oReady & (iByteValid | iFlush));
    emit_ok    = !oTxStart && !iTxFull;
    cnt_inc    = cnt_q + CNT_W'(1);
    dig_sel    = 3'(ADDR_DIGITS - 1) - idx_q[2:0];
`ifdef HEXDUMP_ASCII_EN
    buf_we     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (iByteValid) begin
          byte_d  = iByte;
          flush_d = iFlush;
`ifdef HEXDUMP_ASCII_EN
          buf_we  = 1'b1;
`endif
          if (cnt_q == '0) begin
            addr_d  = iAddr;
            idx_d   = '0;
            state_d = S_ADDR;
          end else begin
            state_d = S_HI;
          end
        end else if (iFlush && cnt_q != '0) begin
`ifdef HEXDUMP_ASCII_EN
          idx_d   = pad_len(cnt_q);
          state_d = S_PAD;
`else
          state_d = S_CR;
`endif
        end
      end
      S_ADDR: begin
        char_c = hex_char(addr_q[{dig_sel, 2'b00} +: 4]);
        if (emit_ok) begin
          if (idx_q == IDX_W'(ADDR_DIGITS - 1)) state_d = S_COLON;
          else                                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_COLON: begin
        char_c = 8'h3A;
        if (emit_ok) state_d = S_SP0;
      end
      S_SP0: begin
        char_c = 8'h20;
        if (emit_ok) state_d = S_HI;
      end
      S_HI: begin
        char_c = hex_char(byte_q[7:4]);
        if (emit_ok) state_d = S_LO;
      end
      S_LO: begin
        char_c = hex_char(byte_q[3:0]);
        if (emit_ok) state_d = S_SP1;
      end
      S_SP1: begin
        char_c = 8'h20;
        if (emit_ok) begin
          cnt_d   = cnt_inc;
          flush_d = 1'b0;
          if (cnt_inc == CNT_W'(BYTES_PER_LINE)) begin
`ifdef HEXDUMP_ASCII_EN
            idx_d   = '0;
            state_d = S_ASC;
`else
            state_d = S_CR;
`endif
          end else if (flush_q) begin
`ifdef HEXDUMP_ASCII_EN
            idx_d   = pad_len(cnt_inc);
            state_d = S_PAD;
`else
            state_d = S_CR;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef HEXDUMP_ASCII_EN
      S_PAD: begin
        char_c = 8'h20;
        if (emit_ok) begin
          if (idx_q <= IDX_W'(1)) begin
            idx_d   = '0;
            state_d = S_ASC;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      S_ASC: begin
        // idx 0: ' ', 1: '|', 2..cnt+1: stored bytes, cnt+2: closing '|'
        if (idx_q == IDX_W'(0))                       char_c = 8'h20;
        else if (idx_q == IDX_W'(1))                  char_c = 8'h7C;
        else if (idx_q <= IDX_W'(cnt_q) + IDX_W'(1))  char_c = printable(line_buf[BI_W'(idx_q - IDX_W'(2))]);
        else                                          char_c = 8'h7C;
        if (emit_ok) begin
          if (idx_q == IDX_W'(cnt_q) + IDX_W'(2)) state_d = S_CR;
          else                                     idx_d   = idx_q + IDX_W'(1);
        end
      end
`endif
      S_CR: begin
        char_c = 8'h0D;
        if (emit_ok) state_d = S_LF;
      end
      S_LF: begin
        char_c = 8'h0A;
        if (emit_ok) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && emit_ok) begin
      tx_start_d = 1'b1;
      tx_data_d  = char_c;
    end

    ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= 8'h00;
      addr_q   <= 32'h0;
      flush_q  <= 1'b0;
      oReady   <= 1'b1;
      oOverrun <= 1'b0;
      oTxData  <= 8'h00;
      oTxStart <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      flush_q  <= flush_d;
      oReady   <= ready_d;
      oOverrun <= overrun_d;
      oTxData  <= tx_data_d;
      oTxStart <= tx_start_d;
    end
  end

`ifdef HEXDUMP_ASCII_EN
  // Line byte store for the ASCII column; contents only read after being written.
  always_ff @(posedge iClk) begin
    if (buf_we) line_buf[BI_W'(cnt_q)] <= iByte;
  end
`endif

endmodule

// File: tb/tb_flash_hex_dump.sv
// Directed bench for flash_hex_dump with BYTES_PER_LINE=2.
module tb_flash_hex_dump;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iByteValid;
  logic [7:0]  iByte;
  logic [31:0] iAddr;
  logic        iFlush;
  logic        oReady;
  logic        oOverrun;
  logic [7:0]  oTxData;
  logic        oTxStart;
  logic        iTxFull;

  int checks = 0;
  int failures = 0;
  int full_viol = 0;
  int b2b_viol = 0;
  logic prev_start = 1'b0;
  logic [7:0] txq [$];
  string crlf = "\015\012";

  flash_hex_dump #(.BYTES_PER_LINE(2), .ADDR_DIGITS(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iByteValid(iByteValid), .iByte(iByte),
    .iAddr(iAddr), .iFlush(iFlush), .oReady(oReady), .oOverrun(oOverrun),
    .oTxData(oTxData), .oTxStart(oTxStart), .iTxFull(iTxFull)
  );

  always #5 iClk = ~iClk;

  // Capture every UART strobe and police the strobe spacing and full rules.
  always begin
    @(posedge iClk);
    #1;
    if (iRst_n) begin
      if (oTxStart) begin
        txq.push_back(oTxData);
        if (iTxFull) full_viol++;
        if (prev_start) b2b_viol++;
      end
      prev_start = oTxStart;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge iClk);
    while (!oReady && n < 400) begin
      @(negedge iClk);
      n++;
    end
    check("ready_wait", 32'(oReady), 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input logic [31:0] a, input logic fl);
    wait_ready();
    iByteValid = 1'b1;
    iByte      = b;
    iAddr      = a;
    iFlush     = fl;
    @(negedge iClk);
    iByteValid = 1'b0;
    iFlush     = 1'b0;
  endtask

  task automatic flush();
    wait_ready();
    iFlush = 1'b1;
    @(negedge iClk);
    iFlush = 1'b0;
  endtask

  task automatic wait_chars(input int n);
    int k = 0;
    while (txq.size() < n && k < 600) begin
      @(negedge iClk);
      k++;
    end
    repeat (8) @(negedge iClk);
  endtask

  task automatic check_line(input string tag, input string exp);
    logic [7:0] got;
    wait_chars(exp.len());
    check({tag, "_len"}, 32'(txq.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < txq.size()) ? txq[i] : 8'h00;
      check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(exp[i]));
    end
    check({tag, "_b2b"}, 32'(b2b_viol), 32'd0);
    check({tag, "_fullstrobe"}, 32'(full_viol), 32'd0);
    txq.delete();
  endtask

  initial begin
    int saved;
    iRst_n = 1'b0; iByteValid = 1'b0; iByte = 8'h00; iAddr = 32'h0;
    iFlush = 1'b0; iTxFull = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_overrun", 32'(oOverrun), 32'd0);
    check("rst_txdata", 32'(oTxData), 32'h00);
    check("rst_txstart", 32'(oTxStart), 32'd0);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Byte path: full two-byte line.
    send(8'hA5, 32'h0000_0010, 1'b0);
    send(8'h3C, 32'h0000_0000, 1'b0);
`ifdef HEXDUMP_ASCII_EN
    check_line("line", {"00000010: A5 3C  |.<|", crlf});
`else
    check_line("line", {"00000010: A5 3C ", crlf});
`endif

    // Back-pressure in the middle of the address prefix.
    send(8'h11, 32'h0000_0020, 1'b0);
    repeat (7) @(negedge iClk);
    iTxFull = 1'b1;
    saved = txq.size();
    repeat (50) @(negedge iClk);
    check("bp_hold", 32'(txq.size()), 32'(saved));
    iTxFull = 1'b0;
    @(negedge iClk);
    check("bp_resume", 32'(txq.size()), 32'(saved + 1));
    send(8'h22, 32'h0000_0000, 1'b0);
`ifdef HEXDUMP_ASCII_EN
    check_line("bp", {"00000020: 11 22  |..|", crlf});
`else
    check_line("bp", {"00000020: 11 22 ", crlf});
`endif

    // Overrun: strobe while busy is dropped and sticks.
    send(8'h5A, 32'h0000_0030, 1'b0);
    check("ovr_busy", 32'(oReady), 32'd0);
    iByteValid = 1'b1; iByte = 8'hFF; iAddr = 32'hFFFF_FFFF;
    @(negedge iClk);
    iByteValid = 1'b0;
    check("ovr_set", 32'(oOverrun), 32'd1);
    send(8'h7E, 32'h0000_0000, 1'b0);
`ifdef HEXDUMP_ASCII_EN
    check_line("ovr", {"00000030: 5A 7E  |Z~|", crlf});
`else
    check_line("ovr", {"00000030: 5A 7E ", crlf});
`endif
    check("ovr_sticky", 32'(oOverrun), 32'd1);

    // Flush of a partial line.
    send(8'h41, 32'h0000_0000, 1'b0);
    flush();
`ifdef HEXDUMP_ASCII_EN
    check_line("flush", {"00000000: 41     |A|", crlf});
`else
    check_line("flush", {"00000000: 41 ", crlf});
`endif

    // Flush with an empty line produces nothing.
    flush();
    repeat (40) @(negedge iClk);
    check("flush_empty", 32'(txq.size()), 32'd0);
    check("flush_empty_rdy", 32'(oReady), 32'd1);

    // Byte and flush in the same cycle.
    send(8'h42, 32'h0000_0044, 1'b1);
`ifdef HEXDUMP_ASCII_EN
    check_line("bytefl", {"00000044: 42     |B|", crlf});
`else
    check_line("bytefl", {"00000044: 42 ", crlf});
`endif

    // Reset in the middle of the address prefix.
    send(8'h99, 32'hABCD_1234, 1'b0);
    repeat (6) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("mrst_txstart", 32'(oTxStart), 32'd0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    check("mrst_ready", 32'(oReady), 32'd1);
    check("mrst_overrun", 32'(oOverrun), 32'd0);
    txq.delete();
    send(8'h00, 32'h0000_00FF, 1'b0);
    send(8'h01, 32'h0000_0000, 1'b0);
`ifdef HEXDUMP_ASCII_EN
    check_line("mrst", {"000000FF: 00 01  |..|", crlf});
`else
    check_line("mrst", {"000000FF: 00 01 ", crlf});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
